// File: rtl/unidade_acesso_memoria_pkg.sv
// Shared types and default widths for the data-memory access unit.
package unidade_acesso_memoria_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        ESCRITA,
        LEITURA
    } estadoT;

    localparam int LARGURA_DADO_PADRAO = 8;
    localparam int LARGURA_END_PADRAO  = 8;
    localparam int LARGURA_QTD_PADRAO  = 4;

endpackage

// File: rtl/unidade_acesso_memoria_if.sv
// Datapath request/response handshake plus the memory-side bus, seen from the access unit.
interface unidade_acesso_memoria_if
    import unidade_acesso_memoria_pkg::*;
#(
    parameter int LARGURA_DADO = LARGURA_DADO_PADRAO,
    parameter int LARGURA_END  = LARGURA_END_PADRAO,
    parameter int LARGURA_QTD  = LARGURA_QTD_PADRAO
) ();

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_escrita;
    logic [LARGURA_END-1:0]  req_endereco;
    logic [LARGURA_DADO-1:0] req_dado;
    logic [LARGURA_QTD-1:0]  req_qtd;
    logic                    cancelar;
    logic                    resp_valid;
    logic [LARGURA_DADO-1:0] resp_dado;
    logic [LARGURA_END-1:0]  Endereco_mem;
    logic [LARGURA_DADO-1:0] DadoEscr;
    logic                    EscMem;
    logic                    LerMem;
    logic [LARGURA_DADO-1:0] DadoLido;

    // The access unit is the initiator on the memory bus.
    modport master (
        input  req_valid, req_escrita, req_endereco, req_dado, req_qtd, cancelar, DadoLido,
        output req_ready, resp_valid, resp_dado, Endereco_mem, DadoEscr, EscMem, LerMem
    );

    modport slave (
        output req_valid, req_escrita, req_endereco, req_dado, req_qtd, cancelar, DadoLido,
        input  req_ready, resp_valid, resp_dado, Endereco_mem, DadoEscr, EscMem, LerMem
    );

endinterface

// File: rtl/unidade_acesso_memoria_contador_rajada.sv
// Burst bookkeeping: wrapping address, remaining beats and per-beat read latency.
module contador_rajada #(
    parameter int LARGURA_END      = 8,
    parameter int LARGURA_QTD      = 4,
    parameter int LATENCIA_LEITURA = 0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   carregar,
    input  logic                   ativo,
    input  logic                   avancar,
    input  logic [LARGURA_END-1:0] enderecoInicial,
    input  logic [LARGURA_QTD-1:0] qtd,
    output logic [LARGURA_END-1:0] endereco,
    output logic                   beat_fim,
    output logic                   ultimo
);

    localparam int LARGURA_LAT = (LATENCIA_LEITURA > 0) ? $clog2(LATENCIA_LEITURA + 1) : 1;
    localparam logic [LARGURA_QTD:0] UM = 1;

    logic [LARGURA_LAT-1:0] latencia;
    logic [LARGURA_QTD:0]   restante;

    assign beat_fim = (latencia == LARGURA_LAT'(LATENCIA_LEITURA));
    assign ultimo   = (restante == UM);

    // A zero count means a full-length burst, so the counter is one bit wider than qtd.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            endereco <= '0;
            restante <= '0;
            latencia <= '0;
        end else if (carregar) begin
            endereco <= enderecoInicial;
            restante <= (qtd == '0) ? {1'b1, {LARGURA_QTD{1'b0}}} : {1'b0, qtd};
            latencia <= '0;
        end else if (ativo) begin
            if (beat_fim) begin
                latencia <= '0;
                if (avancar) begin
                    endereco <= endereco + LARGURA_END'(1);
                    restante <= restante - UM;
                end
            end else begin
                latencia <= latencia + LARGURA_LAT'(1);
            end
        end
    end

endmodule

// File: rtl/unidade_acesso_memoria.sv
// Initiator side of the data-memory interface: single stores and (burst) loads, one response pulse per beat.
module unidade_acesso_memoria
    import unidade_acesso_memoria_pkg::*;
#(
    parameter int LARGURA_DADO     = LARGURA_DADO_PADRAO,
    parameter int LARGURA_END      = LARGURA_END_PADRAO,
    parameter int LARGURA_QTD      = LARGURA_QTD_PADRAO,
    parameter int LATENCIA_LEITURA = 0
) (
    input logic                      clock,
    input logic                      reset_n,
    unidade_acesso_memoria_if.master bus
);

    estadoT estado, estadoProx;

    logic                    reqReady, reqReadyProx;
    logic                    respValid, respValidProx;
    logic [LARGURA_DADO-1:0] respDado, respDadoProx;
    logic [LARGURA_DADO-1:0] dadoEscr, dadoEscrProx;
    logic                    escMem, escMemProx;
    logic                    lerMem, lerMemProx;
    logic                    cancelVisto, cancelVistoProx;
    logic                    carregar, avancar, cancelaAgora;
    logic                    beatFim, ultimo;
    logic [LARGURA_END-1:0]  endereco;

    contador_rajada #(
        .LARGURA_END     (LARGURA_END),
        .LARGURA_QTD     (LARGURA_QTD),
        .LATENCIA_LEITURA(LATENCIA_LEITURA)
    ) uContador (
        .clock          (clock),
        .reset_n        (reset_n),
        .carregar       (carregar),
        .ativo          (estado == LEITURA),
        .avancar        (avancar),
        .enderecoInicial(bus.req_endereco),
        .qtd            (bus.req_qtd),
        .endereco       (endereco),
        .beat_fim       (beatFim),
        .ultimo         (ultimo)
    );

    // Next-state and next-output values; every output is then registered below.
    always_comb begin
        estadoProx      = estado;
        respValidProx   = 1'b0;
        respDadoProx    = respDado;
        dadoEscrProx    = dadoEscr;
        escMemProx      = 1'b0;
        lerMemProx      = 1'b0;
        cancelVistoProx = 1'b0;
        carregar        = 1'b0;
        avancar         = 1'b0;
        cancelaAgora    = cancelVisto | bus.cancelar;

        unique case (estado)
            OCIOSO: begin
                if (bus.req_valid && reqReady) begin
                    carregar = 1'b1;
                    if (bus.req_escrita) begin
                        estadoProx   = ESCRITA;
                        escMemProx   = 1'b1;
                        dadoEscrProx = bus.req_dado;
                    end else begin
                        estadoProx = LEITURA;
                        lerMemProx = 1'b1;
                    end
                end
            end
            ESCRITA: begin
                estadoProx    = OCIOSO;
                respValidProx = 1'b1;
                respDadoProx  = dadoEscr;
            end
            LEITURA: begin
                if (beatFim) begin
                    respValidProx = 1'b1;
                    respDadoProx  = bus.DadoLido;
                    if (!ultimo && !cancelaAgora) begin
                        avancar    = 1'b1;
                        lerMemProx = 1'b1;
                    end else begin
                        estadoProx = OCIOSO;
                    end
                end else begin
                    lerMemProx      = 1'b1;
                    cancelVistoProx = cancelaAgora;
                end
            end
            default: estadoProx = OCIOSO;
        endcase

        reqReadyProx = (estadoProx == OCIOSO);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado      <= OCIOSO;
            reqReady    <= 1'b1;
            respValid   <= 1'b0;
            respDado    <= '0;
            dadoEscr    <= '0;
            escMem      <= 1'b0;
            lerMem      <= 1'b0;
            cancelVisto <= 1'b0;
        end else begin
            estado      <= estadoProx;
            reqReady    <= reqReadyProx;
            respValid   <= respValidProx;
            respDado    <= respDadoProx;
            dadoEscr    <= dadoEscrProx;
            escMem      <= escMemProx;
            lerMem      <= lerMemProx;
            cancelVisto <= cancelVistoProx;
        end
    end

    assign bus.req_ready    = reqReady;
    assign bus.resp_valid   = respValid;
    assign bus.resp_dado    = respDado;
    assign bus.Endereco_mem = endereco;
    assign bus.DadoEscr     = dadoEscr;
    assign bus.EscMem       = escMem;
    assign bus.LerMem       = lerMem;

endmodule

// File: doc/unidade_acesso_memoria.md
Name: unidade_acesso_memoria

Overview:
Initiator side of the data-memory interface. It accepts single-byte load/store requests from the processor datapath over a valid/ready handshake. It drives the memory's Endereco_mem/DadoEscr/EscMem/LerMem signals and captures DadoLido. Reads may be bursts of consecutive addresses. Each completed beat is returned to the datapath as a one-cycle response pulse.

Parameters:
LARGURA_DADO, 8, data width (matches memory word)
LARGURA_END, 8, address width
LARGURA_QTD, 4, burst-length field width; value 0 encodes 2**LARGURA_QTD beats
LATENCIA_LEITURA, 0, cycles from LerMem asserted until DadoLido is valid (0 = combinational memory read)

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request this cycle
req_escrita  in  1  1 = store, 0 = load
req_endereco  in  LARGURA_END  start address
req_dado  in  LARGURA_DADO  store data
req_qtd  in  LARGURA_QTD  load beat count (ignored for store)
cancelar  in  1  stop a load burst after the current beat
resp_valid  out  1  one-cycle pulse per completed beat
resp_dado  out  LARGURA_DADO  load: captured DadoLido; store: data written
Endereco_mem  out  LARGURA_END  memory address
DadoEscr  out  LARGURA_DADO  memory write data
EscMem  out  1  memory write enable
LerMem  out  1  memory read enable
DadoLido  in  LARGURA_DADO  memory read data

Behaviour:
- Reset (reset_n=0, asynchronous): state OCIOSO; req_ready=1; resp_valid=0; resp_dado=0; Endereco_mem=0; DadoEscr=0; EscMem=0; LerMem=0; all counters 0. Reset mid-burst drops all outstanding beats and produces no response.
- All outputs are registered. EscMem and LerMem are never both 1.
- req_ready=1 only in OCIOSO. A request is accepted on a rising edge with req_valid && req_ready. Address, data, kind and beat count are latched at that edge.
- OCIOSO:
  - On acceptance of a store, go to ESCRITA.
  - On acceptance of a load, go to LEITURA with beat counter = req_qtd (0 -> 2**LARGURA_QTD) and latency counter = 0.
- ESCRITA (exactly 1 cycle):
  - Drive EscMem=1, Endereco_mem=latched address, DadoEscr=latched data. The memory writes at the end of this cycle.
  - Next cycle: EscMem=0, resp_valid=1, resp_dado=written data, state OCIOSO (req_ready=1 in that same cycle).
- LEITURA:
  - LerMem=1, Endereco_mem=current address held stable for LATENCIA_LEITURA+1 cycles.
  - DadoLido is sampled at the end of the cycle in which latency counter == LATENCIA_LEITURA. That data appears on resp_dado with resp_valid=1 in the following cycle.
  - After the sample, if remaining beats > 1 and cancelar was not seen: address += 1, wrapping modulo 2**LARGURA_END (0xFF -> 0x00), latency counter = 0, and LerMem stays 1 with no bubble.
  - Otherwise LerMem=0 and state returns to OCIOSO.
- Timing, store: accept at edge 0 -> EscMem cycle 1 -> resp_valid cycle 2.
- Timing, load with L=LATENCIA_LEITURA: accept at edge 0. Beat k's LerMem window spans cycles 1+k(L+1) .. (k+1)(L+1). Beat k's resp_valid is in cycle (k+1)(L+1)+1.
- cancelar:
  - Sampled every cycle in LEITURA and remembered until the current beat completes. The current beat still completes and responds; no further beats are issued.
  - Ignored in OCIOSO and ESCRITA.
  - If cancelar arrives during the final beat, it has no effect.
- req_valid while busy is ignored (not queued). The request source must hold its request until req_ready.
- resp_dado holds its last value between pulses.

Decomposition:
- Shared package: state enum {OCIOSO, ESCRITA, LEITURA}; default width constants (LARGURA_DADO=8, LARGURA_END=8).
- One natural sub-module: contador_rajada. It holds the wrapping address increment, remaining-beat counter and latency counter, and exposes a "beat_fim" flag and a "ultimo" flag.

Test Plan:
- Store: req_escrita=1, addr 0x00, data 0xFF -> EscMem=1 for exactly cycle 1 with Endereco_mem=0x00, DadoEscr=0xFF. resp_valid cycle 2 with resp_dado=0xFF. A behavioural memory then holds 0xFF at 0x00.
- Single load, L=0: preload mem[0x01]=0xAA, load addr 0x01, qtd=1 -> LerMem=1 cycle 1 only; resp_valid cycle 2 with resp_dado=0xAA; req_ready back to 1 in cycle 2.
- Burst with wrap, L=0: mem[0xFE]=0x11, [0xFF]=0x22, [0x00]=0x33; load addr 0xFE, qtd=3 -> Endereco_mem 0xFE, 0xFF, 0x00 in cycles 1-3, LerMem continuous; responses 0x11, 0x22, 0x33 in cycles 2-4.
- Latency, L=2: load addr 0x10, qtd=2, mem[0x10]=0x5A, mem[0x11]=0xA5 -> address 0x10 held cycles 1-3, 0x11 held cycles 4-6; resp pulses in cycle 4 (0x5A) and cycle 7 (0xA5).
- Cancel: L=0, load addr 0x20, qtd=0 (16 beats); assert cancelar in cycle 3 -> beats for 0x20, 0x21, 0x22 respond (cycles 2-4); no LerMem from cycle 4; OCIOSO in cycle 4.
- Reset mid-burst: drop reset_n low asynchronously in cycle 2 of a 4-beat load -> all outputs 0 immediately, req_ready=1, no further resp_valid. After release, a store to 0x05 completes normally.
